// File: rtl/mt32_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mt32_pkg
// Purpose  : Shared constants and state encoding for the MT19937 engine.
// Revision : 1.0
// ============================================================================
package mt32_pkg;

    localparam int          MT_N       = 624;
    localparam int          MT_M       = 397;
    localparam logic [31:0] MATRIX_A   = 32'h9908B0DF;
    localparam logic [31:0] UPPER_MASK = 32'h80000000;
    localparam logic [31:0] TEMPER_B   = 32'h9D2C5680;
    localparam logic [31:0] TEMPER_C   = 32'hEFC60000;
    localparam logic [31:0] INIT_MULT  = 32'd1812433253;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEED   = 2'd1,
        RUN_RD = 2'd2,
        RUN_WR = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mt32_twist_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : mt32_twist_engine_if
// Purpose  : Seed/output handshakes plus both state-RAM ports of the engine.
//            master = engine side, slave = environment (consumer + RAM).
// Revision : 1.0
// ============================================================================
interface mt32_twist_engine_if #(
    parameter int A_WIDTH = 10,
    parameter int D_WIDTH = 32
);
    logic               seed_valid;
    logic [31:0]        seed;
    logic               seed_ready;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_data;
    logic [A_WIDTH-1:0] ram_addr0;
    logic               ram_en0;
    logic               ram_wen0;
    logic [D_WIDTH-1:0] ram_wdata0;
    logic [D_WIDTH-1:0] ram_rdata0;
    logic [A_WIDTH-1:0] ram_addr1;
    logic               ram_en1;
    logic               ram_wen1;
    logic [D_WIDTH-1:0] ram_wdata1;
    logic [D_WIDTH-1:0] ram_rdata1;

    modport master (
        input  seed_valid, seed, out_ready, ram_rdata0, ram_rdata1,
        output seed_ready, out_valid, out_data,
        output ram_addr0, ram_en0, ram_wen0, ram_wdata0,
        output ram_addr1, ram_en1, ram_wen1, ram_wdata1
    );

    modport slave (
        output seed_valid, seed, out_ready, ram_rdata0, ram_rdata1,
        input  seed_ready, out_valid, out_data,
        input  ram_addr0, ram_en0, ram_wen0, ram_wdata0,
        input  ram_addr1, ram_en1, ram_wen1, ram_wdata1
    );
endinterface
`default_nettype wire

// File: rtl/mt32_temper.sv
`default_nettype none
// ============================================================================
// Module   : mt32_temper
// Purpose  : Combinational MT19937 output tempering (mod 2^32).
// Revision : 1.0
// ============================================================================
module mt32_temper
    import mt32_pkg::*;
(
    input  wire logic [31:0] y_i,
    output logic      [31:0] y_o
);
    logic [31:0] w_s1, w_s2, w_s3;

    assign w_s1 = y_i  ^ (y_i >> 11);
    assign w_s2 = w_s1 ^ ((w_s1 << 7) & TEMPER_B);
    assign w_s3 = w_s2 ^ ((w_s2 << 15) & TEMPER_C);
    assign y_o  = w_s3 ^ (w_s3 >> 18);
endmodule
`default_nettype wire

// File: rtl/mt32_twist_engine.sv
`default_nettype none
// ============================================================================
// Module   : mt32_twist_engine
// Purpose  : MT19937 seeding and twist engine driving a dual-port state RAM;
//            emits one tempered word per twist step on a valid/ready output.
// Revision : 1.0
// ============================================================================
module mt32_twist_engine
    import mt32_pkg::*;
#(
    parameter int A_WIDTH = 10,
    parameter int D_WIDTH = 32
) (
    input  wire logic           clk,
    input  wire logic           rst,
    mt32_twist_engine_if.master bus
);
    localparam logic [A_WIDTH-1:0] C_LAST = A_WIDTH'(MT_N - 1);
    localparam logic [A_WIDTH-1:0] C_M    = A_WIDTH'(MT_M);
    localparam logic [A_WIDTH-1:0] C_WRAP = A_WIDTH'(MT_N - MT_M);

    state_t             state_q, state_d;
    logic [A_WIDTH-1:0] idx_q, idx_d;
    logic [D_WIDTH-1:0] cur_q, cur_d;       // mt[idx] as it was before this pass rewrote it
    logic [D_WIDTH-1:0] p_q, p_d;           // previous seed word during SEED
    logic               out_valid_q, out_valid_d;
    logic [D_WIDTH-1:0] out_data_q, out_data_d;

    logic               w_seed_ready, w_seed_fire;
    logic [A_WIDTH-1:0] w_idx_next, w_idx_far;
    logic [D_WIDTH-1:0] w_seed_word, w_y, w_new, w_tempered;
    logic [A_WIDTH-1:0] w_addr0, w_addr1;
    logic               w_en0, w_wen0, w_en1;
    logic [D_WIDTH-1:0] w_wdata0;

    // Neighbour indices wrap modulo 624 without a divider.
    assign w_idx_next  = (idx_q == C_LAST) ? '0 : idx_q + 1'b1;
    assign w_idx_far   = (idx_q >= C_WRAP) ? idx_q - C_WRAP : idx_q + C_M;

    assign w_seed_ready = (state_q != SEED);
    assign w_seed_fire  = bus.seed_valid & w_seed_ready;

    // Word 0 is the seed itself; later words follow the init_genrand recurrence.
    assign w_seed_word = (idx_q == '0) ? p_q
                       : INIT_MULT * (p_q ^ (p_q >> 30)) + D_WIDTH'(idx_q);

    // Twist: port0 returned mt[idx+1], port1 returned mt[idx+397].
    assign w_y   = (cur_q & UPPER_MASK) | (bus.ram_rdata0 & ~UPPER_MASK);
    assign w_new = bus.ram_rdata1 ^ (w_y >> 1) ^ (w_y[0] ? MATRIX_A : '0);

    mt32_temper u_temper (
        .y_i (w_new),
        .y_o (w_tempered)
    );

    // Next-state, RAM control and output register updates.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cur_d       = cur_q;
        p_d         = p_q;
        out_valid_d = out_valid_q & ~bus.out_ready;
        out_data_d  = out_data_q;
        w_addr0     = '0;
        w_addr1     = '0;
        w_en0       = 1'b0;
        w_wen0      = 1'b0;
        w_en1       = 1'b0;
        w_wdata0    = '0;

        case (state_q)
            SEED: begin
                w_en0    = 1'b1;
                w_wen0   = 1'b1;
                w_addr0  = idx_q;
                w_wdata0 = w_seed_word;
                p_d      = w_seed_word;
                if (idx_q == C_LAST) begin
                    idx_d   = '0;
                    state_d = RUN_RD;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            RUN_RD: begin
                w_en0   = 1'b1;
                w_en1   = 1'b1;
                w_addr0 = w_idx_next;
                w_addr1 = w_idx_far;
                // Hold off the twist while an unaccepted word is pending.
                if (!(out_valid_q && !bus.out_ready)) begin
                    state_d = RUN_WR;
                end
            end
            RUN_WR: begin
                w_en0       = 1'b1;
                w_wen0      = 1'b1;
                w_addr0     = idx_q;
                w_wdata0    = w_new;
                out_valid_d = 1'b1;
                out_data_d  = w_tempered;
                cur_d       = bus.ram_rdata0;
                idx_d       = w_idx_next;
                state_d     = RUN_RD;
            end
            default: ;
        endcase

        // A seed handshake (IDLE or mid-run) restarts seeding and drops any work in flight.
        if (w_seed_fire) begin
            state_d     = SEED;
            idx_d       = '0;
            p_d         = bus.seed;
            cur_d       = bus.seed;
            out_valid_d = 1'b0;
            out_data_d  = out_data_q;
            w_en0       = 1'b0;
            w_wen0      = 1'b0;
            w_en1       = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cur_q       <= '0;
            p_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cur_q       <= cur_d;
            p_q         <= p_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.seed_ready = w_seed_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.ram_addr0  = w_addr0;
    assign bus.ram_en0    = w_en0;
    assign bus.ram_wen0   = w_wen0;
    assign bus.ram_wdata0 = w_wdata0;
    assign bus.ram_addr1  = w_addr1;
    assign bus.ram_en1    = w_en1;
    assign bus.ram_wen1   = 1'b0;
    assign bus.ram_wdata1 = '0;
endmodule
`default_nettype wire
